// File: rtl/rect_blitter_pkg.sv
// rtl/rect_blitter_pkg.sv - shared constants, colours and engine state encoding for the rectangle blitter
package rect_blitter_pkg;

  localparam int DEF_COORD_W  = 8;
  localparam int DEF_COLOUR_W = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;
  localparam logic [2:0] COLOUR_RED   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2
  } blit_state_e;

endpackage

// File: rtl/blit_cmd_fifo.sv
// rtl/blit_cmd_fifo.sv - two-entry synchronous command FIFO feeding the blit engine
module blit_cmd_fifo #(
  parameter int DATA_W = 35
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign rdata   = mem_q[rd_ptr_q];
  // A pop never frees room for a same-cycle push: the push is judged on the current fill.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rect_blitter.sv
// rtl/rect_blitter.sv - rasterises queued rectangle fills into one clipped pixel write per clock
module rect_blitter
  import rect_blitter_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COORD_W-1:0]  cmd_x,
  input  logic [COORD_W-1:0]  cmd_y,
  input  logic [COORD_W-1:0]  cmd_w,
  input  logic [COORD_W-1:0]  cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                pix_plot,
  output logic                busy,
  output logic                done
);

  localparam int CMD_W = 4 * COORD_W + COLOUR_W;
  localparam logic [COORD_W-1:0] ONE   = 1;
  localparam logic [COORD_W:0]   LIM_X = (COORD_W + 1)'(SCREEN_W);
  localparam logic [COORD_W:0]   LIM_Y = (COORD_W + 1)'(SCREEN_H);

  logic              fifo_full, fifo_empty, push, pop, more;
  logic [CMD_W-1:0]  fifo_rdata;
  logic [COORD_W-1:0]  rd_x, rd_y, rd_w, rd_h;
  logic [COLOUR_W-1:0] rd_colour;
  logic [COORD_W:0]    sum_x, sum_y;

  blit_state_e         state_q, state_d;
  logic [COORD_W-1:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [COORD_W-1:0]  dx_q, dx_d, dy_q, dy_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [COORD_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [COLOUR_W-1:0] pix_colour_q, pix_colour_d;
  logic                pix_plot_q, pix_plot_d, done_q, done_d;

  assign cmd_ready = !fifo_full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign {rd_x, rd_y, rd_w, rd_h, rd_colour} = fifo_rdata;

  blit_cmd_fifo #(.DATA_W(CMD_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One extra bit keeps the sums from wrapping back onto the visible screen.
  assign sum_x = {1'b0, x0_q} + {1'b0, dx_q};
  assign sum_y = {1'b0, y0_q} + {1'b0, dy_q};

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    colour_d     = colour_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_colour_d = pix_colour_q;
    pix_plot_d   = 1'b0;
    done_d       = 1'b0;
    pop          = 1'b0;
    // Whether a command will be waiting next cycle, counting a same-cycle push and LOAD's own pop.
    more = push || ((state_q == ST_LOAD) ? fifo_full : !fifo_empty);

    unique case (state_q)
      ST_IDLE: begin
        if (more) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop      = 1'b1;
        x0_d     = rd_x;
        y0_d     = rd_y;
        w_d      = rd_w;
        h_d      = rd_h;
        colour_d = rd_colour;
        dx_d     = '0;
        dy_d     = '0;
        if (rd_w == '0 || rd_h == '0) begin
          done_d  = 1'b1;
          state_d = more ? ST_LOAD : ST_IDLE;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        pix_x_d      = sum_x[COORD_W-1:0];
        pix_y_d      = sum_y[COORD_W-1:0];
        pix_colour_d = colour_q;
        pix_plot_d   = (sum_x < LIM_X) && (sum_y < LIM_Y);
        if (dx_q == w_q - ONE) begin
          dx_d = '0;
          if (dy_q == h_q - ONE) begin
            done_d  = 1'b1;
            state_d = more ? ST_LOAD : ST_IDLE;
          end else begin
            dy_d = dy_q + ONE;
          end
        end else begin
          dx_d = dx_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      colour_q     <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= '0;
      pix_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      colour_q     <= colour_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_colour_q <= pix_colour_d;
      pix_plot_q   <= pix_plot_d;
      done_q       <= done_d;
    end
  end

  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_colour = pix_colour_q;
  assign pix_plot   = pix_plot_q;
  assign done       = done_q;
  assign busy       = !fifo_empty || (state_q == ST_DRAW);

endmodule

// File: tb/tb_rect_blitter.sv
// tb/tb_rect_blitter.sv - directed self-checking bench for rect_blitter
module tb_rect_blitter;
  import rect_blitter_pkg::*;

  logic       clock, reset, cmd_valid, cmd_ready;
  logic [7:0] cmd_x, cmd_y, cmd_w, cmd_h, pix_x, pix_y;
  logic [2:0] cmd_colour, pix_colour;
  logic       pix_plot, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc, a0, a1, a2;
  int done_cnt = 0;
  bit done_plot = 0;
  logic [7:0] px_q[$], py_q[$];
  logic [2:0] pc_q[$];
  int pt_q[$], dcyc_q[$];

  rect_blitter dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_colour(cmd_colour),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_plot(pix_plot),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pix_plot === 1'b1) begin
      px_q.push_back(pix_x);
      py_q.push_back(pix_y);
      pc_q.push_back(pix_colour);
      pt_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      dcyc_q.push_back(cyc);
      done_plot = pix_plot;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    px_q.delete(); py_q.delete(); pc_q.delete(); pt_q.delete(); dcyc_q.delete();
    done_cnt  = 0;
    done_plot = 0;
  endtask

  // Called just after a posedge; returns just after the accepting posedge with cmd_valid still high.
  task automatic send(input logic [7:0] x, y, w, h, input logic [2:0] c);
    int n = 0;
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_colour = c;
    @(negedge clock);
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    acc_cyc = cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int n, input int lim);
    int k = 0;
    while (done_cnt < n && k < lim) begin
      @(posedge clock);
      k++;
    end
    if (done_cnt < n) chk("done_timeout", done_cnt, n);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;
    @(negedge clock);
    chk("rst_ready_in_reset", cmd_ready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_plot", pix_plot, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_xyc", {pix_x, pix_y, pix_colour}, 0);
    chk("rst_ready_held", cmd_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready_after", cmd_ready, 1);

    // 1: plain 4x2 fill
    @(posedge clock); #1;
    clr_mon();
    send(8'd10, 8'd20, 8'd4, 8'd2, COLOUR_GREEN);
    cmd_valid = 1'b0;
    wait_done(1, 100);
    @(negedge clock);
    chk("t1_busy_low", busy, 0);
    repeat (4) @(negedge clock);
    chk("t1_nplots", px_q.size(), 8);
    for (int i = 0; i < 8 && i < px_q.size(); i++) begin
      chk("t1_x", px_q[i], 10 + i % 4);
      chk("t1_y", py_q[i], 20 + i / 4);
      chk("t1_col", pc_q[i], 2);
    end
    chk("t1_ndone", done_cnt, 1);
    chk("t1_done_cyc", dcyc_q[0], acc_cyc + 10);
    chk("t1_done_with_plot", done_plot, 1);

    // 2: zero width
    @(posedge clock); #1;
    clr_mon();
    send(8'd30, 8'd40, 8'd0, 8'd5, COLOUR_RED);
    cmd_valid = 1'b0;
    wait_done(1, 50);
    @(negedge clock);
    chk("t2_busy_low", busy, 0);
    repeat (4) @(negedge clock);
    chk("t2_nplots", px_q.size(), 0);
    chk("t2_ndone", done_cnt, 1);
    chk("t2_done_cyc", dcyc_q[0], acc_cyc + 2);

    // 3: clipping at the bottom-right corner
    @(posedge clock); #1;
    clr_mon();
    send(8'd158, 8'd119, 8'd4, 8'd2, COLOUR_WHITE);
    cmd_valid = 1'b0;
    wait_done(1, 100);
    repeat (4) @(negedge clock);
    chk("t3_nplots", px_q.size(), 2);
    chk("t3_p0", {px_q[0], py_q[0]}, {8'd158, 8'd119});
    chk("t3_p1", {px_q[1], py_q[1]}, {8'd159, 8'd119});
    chk("t3_ndone", done_cnt, 1);
    chk("t3_done_cyc", dcyc_q[0], acc_cyc + 10);

    // 4: three commands back to back
    @(posedge clock); #1;
    clr_mon();
    send(8'd0, 8'd0, 8'd3, 8'd1, COLOUR_WHITE);  a0 = acc_cyc;
    send(8'd5, 8'd5, 8'd2, 8'd2, COLOUR_RED);    a1 = acc_cyc;
    send(8'd20, 8'd30, 8'd1, 8'd2, COLOUR_GREEN); a2 = acc_cyc;
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("t4_ready_low_full", cmd_ready, 0);
    wait_done(3, 200);
    repeat (4) @(negedge clock);
    chk("t4_acc1", a1 - a0, 1);
    chk("t4_acc2", a2 - a0, 2);
    chk("t4_nplots", px_q.size(), 9);
    chk("t4_ndone", done_cnt, 3);
    chk("t4_done0", dcyc_q[0], a0 + 5);
    chk("t4_done1", dcyc_q[1], a0 + 10);
    chk("t4_done2", dcyc_q[2], a0 + 13);
    chk("t4_b_first_cyc", pt_q[3], a0 + 7);
    chk("t4_b_first", {px_q[3], py_q[3], pc_q[3]}, {8'd5, 8'd5, COLOUR_RED});
    chk("t4_c_last", {px_q[8], py_q[8], pc_q[8]}, {8'd20, 8'd31, COLOUR_GREEN});

    // 5: reset at the 5th pixel of a 16x1 command
    @(posedge clock); #1;
    clr_mon();
    send(8'd0, 8'd50, 8'd16, 8'd1, COLOUR_RED);
    cmd_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t5_plot", pix_plot, 0);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_nplots_at_rst", px_q.size(), 5);
    repeat (20) @(negedge clock);
    chk("t5_nplots_after", px_q.size(), 5);
    chk("t5_ndone", done_cnt, 0);
    @(posedge clock); #1;
    clr_mon();
    send(8'd2, 8'd3, 8'd2, 8'd1, COLOUR_BLACK);
    cmd_valid = 1'b0;
    wait_done(1, 50);
    repeat (2) @(negedge clock);
    chk("t5_new_nplots", px_q.size(), 2);
    chk("t5_new_last", {px_q[1], py_q[1], pc_q[1]}, {8'd3, 8'd3, COLOUR_BLACK});
    chk("t5_new_done_cyc", dcyc_q[0], acc_cyc + 4);

    // 6: full-screen clear with colour 0
    @(posedge clock); #1;
    clr_mon();
    send(8'd0, 8'd0, 8'd160, 8'd120, COLOUR_BLACK);
    cmd_valid = 1'b0;
    wait_done(1, 20000);
    repeat (2) @(negedge clock);
    chk("t6_nplots", px_q.size(), 19200);
    chk("t6_last", {px_q[px_q.size()-1], py_q[py_q.size()-1]}, {8'd159, 8'd119});
    chk("t6_done_with_plot", done_plot, 1);
    chk("t6_done_cyc", dcyc_q[0], acc_cyc + 3 + 19199);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
